// File: rtl/comb_unit_scheduler.sv
// Round-robin arbiter that lends one shared multi-mode combinational unit to three requesters,
// holds the operands for a settle window, captures the result and returns it over valid/ready.
module comb_unit_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RES_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req_valid,
  input  logic [11:0]      req_op,
  output logic [2:0]       req_ready,
  output logic             cc_en,
  output logic [1:0]       cc_mode,
  output logic [3:0]       cc_op,
  input  logic [RES_W-1:0] cc_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      txn_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             cc_en_q, cc_en_d;
  logic [1:0]       cc_mode_q, cc_mode_d;
  logic [3:0]       cc_op_q, cc_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]      txn_cnt_q;
  logic             done;

  logic [1:0] p0, p1, p2, gid;
  logic       gvld;
  logic [3:0] gop;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order starts at the round-robin pointer; the pointer only ever holds 0..2.
  always_comb begin
    p0   = rr_ptr_q;
    p1   = rr_next(p0);
    p2   = rr_next(p1);
    gvld = 1'b1;
    gid  = p0;
    if (req_valid[p0])      gid = p0;
    else if (req_valid[p1]) gid = p1;
    else if (req_valid[p2]) gid = p2;
    else                    gvld = 1'b0;
    gop = req_op[{gid, 2'b00} +: 4];
  end

  assign req_ready = (gvld && state_q == IDLE && rst_n) ? (3'b001 << gid) : 3'b000;
  assign done      = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    cc_en_d     = cc_en_q;
    cc_mode_d   = cc_mode_q;
    cc_op_d     = cc_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (gvld) begin
          cc_en_d   = 1'b1;
          cc_mode_d = gid;
          cc_op_d   = gop;
          cnt_d     = CNT_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        rsp_data_d  = cc_res;
        rsp_id_d    = cc_mode_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cc_en_d     = 1'b0;
          cc_mode_d   = 2'd0;
          cc_op_d     = 4'd0;
          rr_ptr_d    = rr_next(cc_mode_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      cnt_q       <= 4'd0;
      cc_en_q     <= 1'b0;
      cc_mode_q   <= 2'd0;
      cc_op_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      cc_en_q     <= cc_en_d;
      cc_mode_q   <= cc_mode_d;
      cc_op_q     <= cc_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Completed-response counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    txn_cnt_q <= 16'd0;
    else if (done) txn_cnt_q <= txn_cnt_q + 16'd1;
  end

  assign cc_en     = cc_en_q;
  assign cc_mode   = cc_mode_q;
  assign cc_op     = cc_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_comb_unit_scheduler.sv
// Scoreboard bench for comb_unit_scheduler: a behavioural model of the shared unit and of the
// round-robin/latency rules predicts every output each cycle; a monitor compares on the falling edge.
module tb_comb_unit_scheduler;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [11:0] req_op;
  logic [2:0]  req_ready;
  logic        cc_en;
  logic [1:0]  cc_mode;
  logic [3:0]  cc_op;
  logic [7:0]  cc_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [15:0] txn_cnt;

  always #5 clk = ~clk;

  comb_unit_scheduler #(.SETTLE_CYCLES(S), .RES_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .cc_en(cc_en), .cc_mode(cc_mode), .cc_op(cc_op), .cc_res(cc_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  // Shared unit: 0 = encoder/demux, 1 = decoder/mux, 2 = decoder/full-adder.
  function automatic logic [7:0] unit_f(input logic [1:0] m, input logic [3:0] op);
    logic [7:0] r;
    logic [3:0] one;
    r   = 8'h00;
    one = 4'b0001;
    case (m)
      2'd0: begin
        r[3:0] = op[0] ? (one << op[2:1]) : 4'b0000;
        if (op[3])      r[5:4] = 2'd3;
        else if (op[2]) r[5:4] = 2'd2;
        else if (op[1]) r[5:4] = 2'd1;
        else            r[5:4] = 2'd0;
      end
      2'd1: begin
        r[3:0] = one << op[1:0];
        r[4]   = op[op[3:2]];
      end
      2'd2: begin
        r[0] = op[0] ^ op[1] ^ op[2];
        r[1] = (op[0] & op[1]) | (op[2] & (op[0] ^ op[1]));
      end
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  assign cc_res = cc_en ? unit_f(cc_mode, cc_op) : 8'hA5;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] id_log[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  int         n_resp   = 0;
  bit         m_busy   = 1'b0;
  int         m_rr     = 0;
  logic [15:0] m_cnt   = 16'd0;
  logic [1:0] cur_id   = 2'd0;
  logic [3:0] cur_op   = 4'd0;
  logic [2:0] acc_mask = 3'b000;
  logic [1:0] last_id  = 2'd0;
  logic [7:0] last_data = 8'd0;
  logic [2:0] exp_rdy;
  bit         exp_v;
  exp_t       e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      exp_rdy = 3'b000;
      if (!m_busy) begin
        for (int k = 0; k < 3; k++) begin
          if (exp_rdy == 3'b000 && req_valid[(m_rr + k) % 3]) exp_rdy = 3'(1 << ((m_rr + k) % 3));
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
      chk("cc_en", 32'(cc_en), 32'(m_busy));
      chk("cc_mode", 32'(cc_mode), m_busy ? 32'(cur_id) : 32'd0);
      chk("cc_op", 32'(cc_op), m_busy ? 32'(cur_op) : 32'd0);
      exp_v = m_busy && (cyc >= acc_cyc + S + 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
          m_busy = 1'b0;
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          if (rsp_ready) begin
            e = sb.pop_front();
            last_id   = e.id;
            last_data = rsp_data;
            id_log.push_back(e.id);
            n_resp++;
            m_rr   = (int'(e.id) + 1) % 3;
            m_cnt  = m_cnt + 16'd1;
            m_busy = 1'b0;
          end
        end
      end else if (exp_rdy != 3'b000) begin
        for (int k = 0; k < 3; k++) if (exp_rdy[k]) cur_id = 2'(k);
        cur_op   = req_op[int'(cur_id) * 4 +: 4];
        e.id     = cur_id;
        e.data   = unit_f(cur_id, cur_op);
        sb.push_back(e);
        acc_mask = acc_mask | exp_rdy;
        acc_cyc  = cyc;
        m_busy   = 1'b1;
      end
    end
  end

  task automatic do_reset();
    req_valid = 3'b000;
    rst_n     = 1'b0;
    sb.delete();
    m_busy   = 1'b0;
    m_rr     = 0;
    m_cnt    = 16'd0;
    acc_mask = 3'b000;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cc", 32'({cc_en, cc_mode, cc_op}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic issue(input int idx, input logic [3:0] op);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_op[idx*4 +: 4] = op;
    req_valid[idx]     = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      if (acc_mask[idx]) begin
        got = 1'b1;
        acc_mask[idx]  = 1'b0;
        req_valid[idx] = 1'b0;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid[idx] = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target);
    for (int n = 0; n < 60 && n_resp < target; n++) @(negedge clk);
    if (n_resp < target) chk("resp_timeout", 32'(n_resp), 32'(target));
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 3'b000;
    req_op    = 12'h000;
    rsp_ready = 1'b0;
    #2;
    do_reset();

    // single request on requester 1
    rsp_ready = 1'b1;
    issue(1, 4'b0110);
    wait_resp(1);
    chk("single_id", 32'(last_id), 32'd1);
    chk("single_data", 32'(last_data), 32'h14);

    // full-adder path, a=1 b=1 c=0 -> sum 0 carry 1
    issue(2, 4'b0011);
    wait_resp(2);
    chk("fa_id", 32'(last_id), 32'd2);
    chk("fa_data", 32'(last_data), 32'h02);

    // fairness with all requesters held high
    @(posedge clk); #1;
    do_reset();
    id_log.delete();
    n_resp    = 0;
    req_op    = 12'($urandom);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 3'b111;
    for (int n = 0; n < 80 && n_resp < 4; n++) begin
      @(posedge clk); #1;
    end
    req_valid = 3'b000;
    acc_mask  = 3'b000;
    chk("fair_count", 32'(id_log.size()), 32'd4);
    if (id_log.size() >= 4) begin
      chk("fair_0", 32'(id_log[0]), 32'd0);
      chk("fair_1", 32'(id_log[1]), 32'd1);
      chk("fair_2", 32'(id_log[2]), 32'd2);
      chk("fair_3", 32'(id_log[3]), 32'd0);
    end
    chk("fair_txn_cnt", 32'(txn_cnt), 32'd4);

    // backpressure: response held for 5 cycles while others wait
    rsp_ready = 1'b0;
    issue(0, 4'($urandom));
    for (int n = 0; n < 20 && !rsp_valid; n++) @(posedge clk);
    #1;
    req_valid = 3'b110;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 3'b000;
    rsp_ready = 1'b1;
    wait_resp(5);

    // reset while settling: the transaction must vanish
    issue(2, 4'($urandom));
    #2;
    do_reset();
    repeat (6) begin
      @(negedge clk);
      chk("rst_settle_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // counter wrap from 0xFFFF
    @(posedge clk); #3;
    force dut.txn_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk); #2;
    release dut.txn_cnt_q;
    n_resp = 0;
    issue(1, 4'($urandom));
    wait_resp(1);
    @(posedge clk); #1;
    chk("wrap_txn_cnt", 32'(txn_cnt), 32'd0);

    // randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~acc_mask;
      acc_mask  = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_op[i*4 +: 4] = 4'($urandom);
          req_valid[i]     = 1'b1;
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    req_valid = 3'b000;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
